// File: rtl/my_design_core.sv
// Registered ID-select capture stage with popcount and capture strobe.
// Optional sticky popcount range check enabled by macro ID_SEL_CHECK_EN.
module my_design_core #(
   parameter  int WIDTH    = 4,
   parameter  int MIN_ONES = 0,
   parameter  int MAX_ONES = 4,
   localparam int OW       = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_ok,
   input  logic [WIDTH-1:0] id_sel,
   output logic [WIDTH-1:0] id_sel_out,
   output logic             id_cap,
   output logic [OW-1:0]    id_ones,
   output logic             id_err
);

   // Reject an empty legal range at elaboration rather than flag every capture.
   if (MIN_ONES > MAX_ONES) begin : g_bad_range
      $error("my_design_core: MIN_ONES must not exceed MAX_ONES");
   end

   logic [OW-1:0] pop;

   // Popcount taken from the incoming select so id_ones lands with id_sel_out.
   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++)
         pop = pop + OW'(id_sel[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         id_sel_out <= '0;
         id_ones    <= '0;
         id_cap     <= 1'b0;
      end else if (id_ok) begin
         id_sel_out <= id_sel;
         id_ones    <= pop;
         id_cap     <= 1'b1;
      end else begin
         id_cap     <= 1'b0;
      end
   end

`ifdef ID_SEL_CHECK_EN
   logic range_bad;

   assign range_bad = (int'(pop) < MIN_ONES) || (int'(pop) > MAX_ONES);

   always_ff @(posedge clk) begin
      if (reset)
         id_err <= 1'b0;
      else if (id_ok && range_bad)
         id_err <= 1'b1;
   end
`else
   assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_my_design_core.sv
// Randomized self-checking bench for my_design_core against a cycle-level model.
// Expects id_err activity only when ID_SEL_CHECK_EN is defined (MIN_ONES=MAX_ONES=1).
module tb_my_design_core;

   localparam int WIDTH = 4;
   localparam int OW    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             id_ok;
   logic [WIDTH-1:0] id_sel;
   logic [WIDTH-1:0] id_sel_out;
   logic             id_cap;
   logic [OW-1:0]    id_ones;
   logic             id_err;

   int total = 0;
   int bad   = 0;

   // reference state
   int exp_sel  = 0;
   int exp_ones = 0;
   int exp_cap  = 0;
   int exp_err  = 0;

   my_design_core #(.WIDTH(WIDTH), .MIN_ONES(1), .MAX_ONES(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .id_ok      (id_ok),
      .id_sel     (id_sel),
      .id_sel_out (id_sel_out),
      .id_cap     (id_cap),
      .id_ones    (id_ones),
      .id_err     (id_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int ones_of(input int v);
      int n = 0;
      for (int i = 0; i < WIDTH; i++)
         if (((v >> i) & 1) == 1) n++;
      return n;
   endfunction

   // Apply one cycle of stimulus, advance the model, then compare all outputs.
   task automatic cycle(input string tag, input bit r, input bit ok, input int s);
      reset  = r;
      id_ok  = ok;
      id_sel = s[WIDTH-1:0];
      @(posedge clk);
      if (r) begin
         exp_sel = 0; exp_ones = 0; exp_cap = 0; exp_err = 0;
      end else if (ok) begin
         exp_sel  = s & ((1 << WIDTH) - 1);
         exp_ones = ones_of(exp_sel);
         exp_cap  = 1;
`ifdef ID_SEL_CHECK_EN
         if (exp_ones != 1) exp_err = 1;
`endif
      end else begin
         exp_cap = 0;
      end
      #1;
      chk({tag, ".sel"},  int'(id_sel_out), exp_sel);
      chk({tag, ".ones"}, int'(id_ones),    exp_ones);
      chk({tag, ".cap"},  int'(id_cap),     exp_cap);
      chk({tag, ".err"},  int'(id_err),     exp_err);
   endtask

   initial begin
      reset = 1'b1; id_ok = 1'b0; id_sel = '0;
      @(posedge clk); #1;

      // reset dominates id_ok
      for (int i = 0; i < 10; i++) cycle("reset", 1, 1, 'hA);

      // single capture then hold with a different input
      cycle("single", 0, 1, 'h5);
      for (int i = 0; i < 3; i++) cycle("hold", 0, 0, 'hF);

      // back-to-back random stream
      for (int i = 0; i < 16; i++) cycle("stream", 0, 1, int'($urandom_range(0, 15)));

      // popcount boundaries
      cycle("pop0", 0, 1, 'h0);
      cycle("pop4", 0, 1, 'hF);

      // reset mid-stream
      cycle("pre_rst", 0, 1, 'hC);
      cycle("mid_rst", 1, 1, 'h3);
      cycle("post_rst", 0, 1, 'h3);

      // range check sequence
      cycle("err_a", 1, 0, 0);
      cycle("err_4", 0, 1, 'h4);
      cycle("err_6", 0, 1, 'h6);
      cycle("err_1", 0, 1, 'h1);
      cycle("err_hold", 0, 0, 'h7);
      cycle("err_rst", 1, 0, 0);

      // random mix of capture, hold and occasional reset
      for (int i = 0; i < 200; i++)
         cycle("rand", ($urandom_range(0, 19) == 0), bit'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
